// File: rtl/uart_dbg_pkg.sv
// Shared constants and types for the debug UART bus protocol (initiator and responder).
package uart_dbg_pkg;

   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] ACK_BYTE  = 8'h4B;

   localparam int unsigned READ_FRAME_LEN  = 5;
   localparam int unsigned WRITE_FRAME_LEN = 10;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_RSP,
      RESPOND
   } dbg_state_t;

endpackage

// File: rtl/uart_bus_initiator_if.sv
// Request/completion port plus the byte streams to and from the UART.
// The master modport is the initiator's view; slave is the environment's view.
interface uart_bus_initiator_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;

   logic        busy;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_error,
      input  rsp_ready,
      output tx_data, tx_valid,
      input  tx_ready,
      input  rx_data, rx_valid,
      output rx_ready,
      output busy
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_error,
      output rsp_ready,
      input  tx_data, tx_valid,
      output tx_ready,
      output rx_data, rx_valid,
      input  rx_ready,
      input  busy
   );

endinterface

// File: rtl/uart_dbg_timeout.sv
// Response timeout: loadable down-counter, expiry pulses when enabled at zero.
// Loaded with TIMEOUT_CYCLES-2 so that the wait ends after TIMEOUT_CYCLES
// silent cycles counted from the last byte event.
module uart_dbg_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // next count: clear has priority over load, then decrement while enabled
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = W'(TIMEOUT_CYCLES - 2);
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/uart_bus_initiator.sv
// Debug UART bus initiator: turns 32-bit read/write requests into command
// frames on the tx byte stream and collects the rx response into a completion.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for a request, stray rx bytes dropped
// SEND     | shifting frame bytes out, one per tx handshake
// WAIT_RSP | collecting response bytes, timeout running on silence
// RESPOND  | completion offered until rsp_ready, rx held off
module uart_bus_initiator
   import uart_dbg_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_bus_initiator_if.master bus
);

   dbg_state_t  state_q,  state_d;
   logic [79:0] frame_q,  frame_d;
   logic        write_q,  write_d;
   logic [3:0]  idx_q,    idx_d;
   logic [1:0]  rxcnt_q,  rxcnt_d;
   logic [31:0] rdata_q,  rdata_d;
   logic        err_q,    err_d;

   logic tmr_load;
   logic tmr_clr;
   logic tmr_en;
   logic tmr_expired;
   logic last_byte;

   uart_dbg_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .load   (tmr_load),
      .clr    (tmr_clr),
      .en     (tmr_en),
      .expired(tmr_expired)
   );

   assign last_byte = write_q ? (idx_q == 4'(WRITE_FRAME_LEN - 1))
                              : (idx_q == 4'(READ_FRAME_LEN - 1));

   // next-state, datapath updates and handshake outputs
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      write_d = write_q;
      idx_d   = idx_q;
      rxcnt_d = rxcnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      tmr_load = 1'b0;
      tmr_clr  = 1'b0;
      tmr_en   = 1'b0;

      bus.req_ready = 1'b0;
      bus.tx_valid  = 1'b0;
      bus.rx_ready  = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.busy      = 1'b1;

      case (state_q)
         IDLE: begin
            bus.busy      = 1'b0;
            bus.req_ready = 1'b1;
            bus.rx_ready  = 1'b1;
            if (bus.req_valid) begin
               // frame bytes LSB first: opcode, addr, wdata, strobes
               frame_d = {4'b0000, bus.req_wstrb, bus.req_wdata, bus.req_addr,
                          bus.req_write ? CMD_WRITE : CMD_READ};
               write_d = bus.req_write;
               idx_d   = '0;
               rxcnt_d = '0;
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = SEND;
            end
         end

         SEND: begin
            bus.tx_valid = 1'b1;
            bus.rx_ready = 1'b1;
            if (bus.tx_ready) begin
               frame_d = {8'h00, frame_q[79:8]};
               idx_d   = idx_q + 4'd1;
               if (last_byte) begin
                  tmr_load = 1'b1;
                  rxcnt_d  = '0;
                  state_d  = WAIT_RSP;
               end
            end
         end

         WAIT_RSP: begin
            bus.rx_ready = 1'b1;
            if (bus.rx_valid) begin
               tmr_load = 1'b1;
               if (write_q) begin
                  err_d   = (bus.rx_data != ACK_BYTE);
                  rdata_d = '0;
                  state_d = RESPOND;
               end else begin
                  rdata_d = {bus.rx_data, rdata_q[31:8]};
                  rxcnt_d = rxcnt_q + 2'd1;
                  if (rxcnt_q == 2'd3) begin
                     err_d   = 1'b0;
                     state_d = RESPOND;
                  end
               end
            end else begin
               tmr_en = 1'b1;
               if (tmr_expired) begin
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = RESPOND;
               end
            end
         end

         RESPOND: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               tmr_clr = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // hold every handshake low while reset is asserted
      if (rst) begin
         bus.req_ready = 1'b0;
         bus.tx_valid  = 1'b0;
         bus.rx_ready  = 1'b0;
         bus.rsp_valid = 1'b0;
         bus.busy      = 1'b0;
      end
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         frame_q <= '0;
         write_q <= 1'b0;
         idx_q   <= '0;
         rxcnt_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         write_q <= write_d;
         idx_q   <= idx_d;
         rxcnt_q <= rxcnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign bus.tx_data   = frame_q[7:0];
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_error = err_q;

endmodule

// File: tb/tb_uart_bus_initiator.sv
// Directed bench for uart_bus_initiator with a frame/response model and a
// per-cycle compare process on the tx stream and completions.
module tb_uart_bus_initiator;

   localparam int T = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_bus_initiator_if bus();

   uart_bus_initiator #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_tx[$];
   logic [32:0] exp_rsp[$];
   logic [7:0]  cap_tx[$];
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data  = 8'h00;
   logic [32:0] rsp_e;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // model: expected frame bytes from the request fields
   task automatic push_frame(logic w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
      exp_tx.push_back(w ? 8'h57 : 8'h52);
      for (int i = 0; i < 4; i++) exp_tx.push_back(a[8*i +: 8]);
      if (w) begin
         for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
         exp_tx.push_back({4'b0000, s});
      end
   endtask

   // compare process
   always @(negedge clk) begin
      if (rst) begin
         exp_tx.delete();
         prev_stall = 1'b0;
         chk("rst_tx_valid", 32'(bus.tx_valid), 0);
         chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
         chk("rst_busy", 32'(bus.busy), 0);
      end else begin
         if (prev_stall) begin
            chk("tx_hold_valid", 32'(bus.tx_valid), 1);
            chk("tx_hold_data", 32'(bus.tx_data), 32'(prev_data));
         end
         if (bus.tx_valid) begin
            if (exp_tx.size() == 0) begin
               chk("tx_unexpected", 32'(bus.tx_valid), 0);
            end else begin
               chk("tx_byte", 32'(bus.tx_data), 32'(exp_tx[0]));
               if (bus.tx_ready) begin
                  void'(exp_tx.pop_front());
                  cap_tx.push_back(bus.tx_data);
               end
            end
         end
         prev_stall = bus.tx_valid && !bus.tx_ready;
         prev_data  = bus.tx_data;
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_rsp.size() == 0) begin
               chk("rsp_unexpected", 32'(bus.rsp_valid), 0);
            end else begin
               rsp_e = exp_rsp.pop_front();
               chk("rsp_rdata", bus.rsp_rdata, rsp_e[31:0]);
               chk("rsp_error", 32'(bus.rsp_error), 32'(rsp_e[32]));
            end
         end
      end
   end

   task automatic do_req(logic w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
      bit ok = 0;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_wstrb = s;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("req_accept_timeout", 32'(bus.req_ready), 1);
      push_frame(w, a, d, s);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_tx_done();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (exp_tx.size() == 0) break;
      end
      chk("tx_drain", 32'(exp_tx.size()), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic send_rx(logic [7:0] b);
      bit ok = 0;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.rx_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("rx_accept_timeout", 32'(bus.rx_ready), 1);
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   // model: read data is the four rx bytes assembled LSB first
   task automatic feed_read(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
      exp_rsp.push_back({1'b0, b3, b2, b1, b0});
      send_rx(b0);
      send_rx(b1);
      send_rx(b2);
      send_rx(b3);
   endtask

   task automatic feed_ack(logic [7:0] b);
      exp_rsp.push_back({(b != 8'h4B), 32'h0});
      send_rx(b);
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            n = i;
            break;
         end
      end
      if (n == 0) chk("rsp_wait_timeout", 32'(bus.rsp_valid), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [7:0] t1_lit [5];
      logic [7:0] t2_lit [10];
      logic [31:0] held_rdata;
      logic        held_err;
      int n;

      t1_lit = '{8'h52, 8'h04, 8'h01, 8'h00, 8'h00};
      t2_lit = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h03};

      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_wstrb = '0;
      bus.rsp_ready = 1'b1;
      bus.tx_ready  = 1'b1;
      bus.rx_data   = '0;
      bus.rx_valid  = 1'b0;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_rx_ready", 32'(bus.rx_ready), 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
      chk("rst_rsp_error", 32'(bus.rsp_error), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_req_ready", 32'(bus.req_ready), 1);
      chk("idle_rx_ready", 32'(bus.rx_ready), 1);
      chk("idle_busy", 32'(bus.busy), 0);
      @(posedge clk);
      #1;

      // 1: read, transmitter always ready
      cap_tx.delete();
      do_req(1'b0, 32'h0000_0104, 32'h0, 4'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t1_tx_valid", 32'(bus.tx_valid), 1);
         chk("t1_tx_data", 32'(bus.tx_data), 32'(t1_lit[i]));
      end
      @(negedge clk);
      chk("t1_tx_idle_after", 32'(bus.tx_valid), 0);
      chk("t1_busy_wait", 32'(bus.busy), 1);
      @(posedge clk);
      #1;
      feed_read(8'hEF, 8'hBE, 8'hAD, 8'hDE);
      wait_rsp(n);
      chk("t1_rsp_latency", 32'(n), 1);
      chk("t1_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
      chk("t1_error", 32'(bus.rsp_error), 0);
      @(posedge clk);
      #1;

      // 2: write with a stalling transmitter
      cap_tx.delete();
      bus.tx_ready = 1'b0;
      do_req(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0011);
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (exp_tx.size() == 0) break;
         bus.tx_ready = ~bus.tx_ready;
      end
      bus.tx_ready = 1'b1;
      chk("t2_drain", 32'(exp_tx.size()), 0);
      chk("t2_frame_len", 32'(cap_tx.size()), 10);
      for (int i = 0; i < 10 && i < cap_tx.size(); i++)
         chk("t2_frame_byte", 32'(cap_tx[i]), 32'(t2_lit[i]));
      feed_ack(8'h4B);
      wait_rsp(n);
      chk("t2_error", 32'(bus.rsp_error), 0);
      chk("t2_rdata", bus.rsp_rdata, 0);
      @(posedge clk);
      #1;

      // 3: bad acknowledge
      do_req(1'b1, 32'h0000_00A0, 32'hCAFE_F00D, 4'hF);
      wait_tx_done();
      feed_ack(8'h00);
      wait_rsp(n);
      chk("t3_error", 32'(bus.rsp_error), 1);
      chk("t3_rdata", bus.rsp_rdata, 0);
      @(posedge clk);
      #1;

      // 4: timeout after two of four read bytes
      do_req(1'b0, 32'h0000_0200, 32'h0, 4'h0);
      wait_tx_done();
      send_rx(8'h11);
      send_rx(8'h22);
      exp_rsp.push_back({1'b1, 32'h0});
      wait_rsp(n);
      chk("t4_timeout_cycles", 32'(n), T);
      chk("t4_error", 32'(bus.rsp_error), 1);
      chk("t4_rdata", bus.rsp_rdata, 0);
      @(posedge clk);
      #1;

      // 5: completion back-pressure, then back-to-back request
      bus.rsp_ready = 1'b0;
      do_req(1'b0, 32'h0000_0300, 32'h0, 4'h0);
      wait_tx_done();
      feed_read(8'h01, 8'h02, 8'h03, 8'h04);
      wait_rsp(n);
      held_rdata = bus.rsp_rdata;
      held_err   = bus.rsp_error;
      chk("t5_rdata", held_rdata, 32'h0403_0201);
      bus.rx_data  = 8'h55;
      bus.rx_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_hold_valid", 32'(bus.rsp_valid), 1);
         chk("t5_hold_rdata", bus.rsp_rdata, 32'h0403_0201);
         chk("t5_hold_error", 32'(bus.rsp_error), 32'(held_err));
         chk("t5_rx_ready", 32'(bus.rx_ready), 0);
      end
      @(posedge clk);
      #1;
      bus.rx_valid  = 1'b0;
      bus.rsp_ready = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h0000_0400;
      bus.req_wdata = 32'hA5A5_0F0F;
      bus.req_wstrb = 4'b1000;
      bus.req_valid = 1'b1;
      @(negedge clk);
      chk("t5_req_ready_in_rsp", 32'(bus.req_ready), 0);
      push_frame(1'b1, 32'h0000_0400, 32'hA5A5_0F0F, 4'b1000);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t5_req_ready_next", 32'(bus.req_ready), 1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      wait_tx_done();
      feed_ack(8'h4B);
      wait_rsp(n);
      chk("t5_b2b_error", 32'(bus.rsp_error), 0);
      @(posedge clk);
      #1;

      // 6: reset in the middle of a write frame
      cap_tx.delete();
      do_req(1'b1, 32'h0000_0500, 32'h0BAD_F00D, 4'hF);
      repeat (3) @(posedge clk);
      #1;
      chk("t6_bytes_before_rst", 32'(cap_tx.size()), 3);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_tx_valid", 32'(bus.tx_valid), 0);
      chk("t6_rst_busy", 32'(bus.busy), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t6_post_tx_valid", 32'(bus.tx_valid), 0);
         chk("t6_post_rsp_valid", 32'(bus.rsp_valid), 0);
         chk("t6_post_busy", 32'(bus.busy), 0);
      end
      @(posedge clk);
      #1;
      cap_tx.delete();
      do_req(1'b0, 32'h0000_0044, 32'h0, 4'h0);
      wait_tx_done();
      chk("t6_frame_len", 32'(cap_tx.size()), 5);
      if (cap_tx.size() > 0) chk("t6_first_byte", 32'(cap_tx[0]), 32'h52);
      feed_read(8'h10, 8'h20, 8'h30, 8'h40);
      wait_rsp(n);
      chk("t6_rdata", bus.rsp_rdata, 32'h4030_2010);
      @(posedge clk);
      #1;
      repeat (3) @(negedge clk);
      chk("end_rsp_queue", 32'(exp_rsp.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_bus_initiator.md
Name: uart_bus_initiator

Overview:
- Initiator end of the debug UART bus protocol: the counterpart of `uart_bus_master`, which is the responder.
- Accepts 32-bit read and write requests on a valid/ready request port and serialises each one into a command frame on a byte stream.
- The byte stream feeds the `uart` TX channel; response bytes come back from the `uart` RX channel and are collected into a completion.
- Used for board-to-board debug links and as the reference stimulus driver in system benches.

Parameters:
- CMD_READ, 8'h52: opcode byte for a read frame.
- CMD_WRITE, 8'h57: opcode byte for a write frame.
- ACK_BYTE, 8'h4B: the only valid write-acknowledge byte.
- TIMEOUT_CYCLES, 5000000: response timeout in clk cycles (100 ms at 50 MHz); must be ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when high together with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_wstrb  in  4  byte-lane write enables
- rsp_valid  out  1  completion available
- rsp_ready  in  1  completion consumed
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_error  out  1  bad acknowledge or timeout
- tx_data  out  8  byte to the UART transmitter
- tx_valid  out  1  tx byte valid
- tx_ready  in  1  UART transmitter can take the byte
- rx_data  in  8  byte from the UART receiver
- rx_valid  in  1  rx byte valid
- rx_ready  out  1  rx byte consumed
- busy  out  1  high in every state except IDLE

Behaviour:
- Frame formats (all multi-byte fields least-significant byte first):
  - Read frame: CMD_READ, addr[7:0] .. addr[31:24]; 5 bytes. Response: 4 data bytes.
  - Write frame: CMD_WRITE, 4 addr bytes, 4 wdata bytes, {4'b0, wstrb}; 10 bytes. Response: 1 byte.
- Reset: state = IDLE.
  - Output values: req_ready=0 during the rst cycle, tx_valid=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, rx_ready=0, busy=0.
  - The byte index and timeout counter clear to 0.
  - Reset mid-frame abandons the frame; no partial completion is produced.
- IDLE:
  - req_ready=1 and rx_ready=1. Stray rx bytes are dropped.
  - On req_valid&req_ready: latch the frame into a byte register, latch req_write, set index=0, go to SEND.
  - The request is sampled only on that cycle.
- SEND:
  - tx_valid=1, tx_data=frame[index].
  - tx_data is held stable until tx_ready.
  - On tx_valid&tx_ready: index increments.
  - On the last byte (index 4 for a read, 9 for a write): go to WAIT_RSP, clear the timer and the rx byte count.
  - rx_ready=1 in SEND; stray bytes are dropped.
- WAIT_RSP:
  - rx_ready=1, so each rx_valid cycle consumes one byte.
  - Read: byte n fills rdata[8n+7:8n]. After the 4th byte, go to RESPOND with rsp_error=0.
  - Write: the 1st byte ends the wait. rsp_error = (byte != ACK_BYTE). rsp_rdata=0. Go to RESPOND.
  - The timer increments every cycle without an rx byte. A received byte reloads it to 0.
  - When the timer reaches TIMEOUT_CYCLES-1: go to RESPOND with rsp_error=1 and rsp_rdata=0; discard any partial read bytes.
  - If an rx byte and the timeout coincide in the same cycle, the byte wins.
- RESPOND:
  - rsp_valid=1. rsp_rdata and rsp_error are held stable.
  - rx_ready=0, so the UART holds any extra byte.
  - On rsp_ready: go to IDLE. A new request can be accepted on the next cycle.
- Latency: request accept to first tx_valid is 1 cycle. Last rx byte to rsp_valid is 1 cycle.
- Only one request is outstanding; there is no pipelining.

Decomposition:
- Shared package `uart_dbg_pkg`:
  - CMD_READ, CMD_WRITE, ACK_BYTE constants, shared with `uart_bus_master`.
  - Frame length constants READ_FRAME_LEN=5, WRITE_FRAME_LEN=10.
  - A dbg_state_t enum {IDLE, SEND, WAIT_RSP, RESPOND}.
- One natural sub-module, `uart_dbg_timeout`: a loadable down-counter with a clear input and an expiry pulse output.
- The FSM, frame builder and rx assembler stay in the top.

Test Plan:
- Read, tx_ready held at 1:
  - Stimulus: req_addr=32'h0000_0104, read.
  - Expect tx bytes 52,04,01,00,00 on consecutive cycles.
  - Then feed rx EF,BE,AD,DE → rsp_valid with rsp_rdata=32'hDEAD_BEEF, rsp_error=0.
- Write with a stalled transmitter:
  - Stimulus: addr=32'h10, wdata=32'h1234_5678, wstrb=4'b0011; tx_ready toggles every other cycle.
  - Expect the 10 bytes 57,10,00,00,00,78,56,34,12,03, each held stable across stalls.
  - Then feed rx 4B → rsp_error=0, rsp_rdata=0.
- Bad acknowledge: write completes, then rx 8'h00 arrives → rsp_error=1.
- Timeout, with TIMEOUT_CYCLES=16:
  - Read is sent and only 2 rx bytes are supplied, then silence.
  - Expect rsp_valid exactly 16 cycles after the 2nd byte, with rsp_error=1, rsp_rdata=0.
- Back-pressure and back-to-back:
  - rsp_ready is held low 5 cycles → rsp_valid, rsp_rdata and rsp_error stay stable, and rx_ready=0.
  - Release rsp_ready → next req accepted on the following cycle.
- Reset mid-frame:
  - Assert rst after the 3rd tx byte of a write.
  - Expect tx_valid=0, busy=0 and no rsp_valid.
  - A new read then produces a clean 5-byte frame starting with 8'h52.
